// File: rtl/cpu_writeback_stage_pkg.sv
// Shared CPU writeback definitions: load-size encodings, result source indices
// and the skid-buffer state type.
package cpu_writeback_stage_pkg;

  localparam logic [1:0] LS_BYTE = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_WORD = 2'd2;

  localparam int unsigned SRC_ALU  = 0;
  localparam int unsigned SRC_LOAD = 1;
  localparam int unsigned SRC_PC4  = 2;
  localparam int unsigned SRC_CSR  = 3;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } wb_buf_state_e;

endpackage

// File: rtl/cpu_writeback_stage_load_extend.sv
// Load data alignment and sign/zero extension for a 32-bit load word.
module cpu_load_extend
  import cpu_writeback_stage_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Halfword loads are half-aligned, so only off_i[1] picks the lane.
  assign byte_v = word_i[{off_i, 3'b000} +: 8];
  assign half_v = word_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o = word_i;
    unique case (size_i)
      LS_BYTE: data_o = {{24{signed_i & byte_v[7]}}, byte_v};
      LS_HALF: data_o = {{16{signed_i & half_v[15]}}, half_v};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/cpu_writeback_stage.sv
// Register-file writeback stage: source select, load extension and a 2-entry
// skid buffer whose head drives the register-file write port and forwarding.
module cpu_writeback_stage
  import cpu_writeback_stage_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 5,
  parameter int unsigned NSRC        = 4,
  parameter int unsigned SELW        = 2,
  parameter int unsigned LOAD_SRC    = SRC_LOAD,
  parameter bit          ZERO_REG_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SELW-1:0]    in_sel,
  input  logic [NSRC*DW-1:0] in_data,
  input  logic [AW-1:0]      in_rd,
  input  logic [1:0]         in_ld_size,
  input  logic               in_ld_signed,
  input  logic [1:0]         in_byte_off,
  output logic               rf_we,
  input  logic               rf_ready,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic               sel_err
);

  wb_buf_state_e state_q, state_d;
  logic          in_ready_q;
  logic          sel_err_q, sel_err_d;
  logic [AW-1:0] head_addr_q, head_addr_d;
  logic [DW-1:0] head_data_q, head_data_d;
  logic [AW-1:0] skid_addr_q, skid_addr_d;
  logic [DW-1:0] skid_data_q, skid_data_d;

  logic [DW-1:0] ld_data;
  logic [DW-1:0] sel_data;
  logic          sel_ok;
  logic          accept;
  logic          discard;
  logic          push;
  logic          pop;

  generate
    if (DW == 32) begin : g_ext
      cpu_load_extend u_load_extend (
        .word_i   (in_data[LOAD_SRC*DW +: DW]),
        .size_i   (in_ld_size),
        .signed_i (in_ld_signed),
        .off_i    (in_byte_off),
        .data_o   (ld_data)
      );
    end else begin : g_no_ext
      assign ld_data = in_data[LOAD_SRC*DW +: DW];
    end
  endgenerate

  // Out-of-range selects fall through with zero data and sel_ok low.
  always_comb begin
    sel_data = '0;
    sel_ok   = 1'b0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (in_sel == SELW'(k)) begin
        sel_ok   = 1'b1;
        sel_data = (k == LOAD_SRC) ? ld_data : in_data[k*DW +: DW];
      end
    end
  end

  assign accept  = in_valid & in_ready_q;
  assign discard = ZERO_REG_EN && (in_rd == '0);
  assign push    = accept & ~discard;
  assign rf_we   = (state_q != BUF_EMPTY);
  assign pop     = rf_we & rf_ready;

  assign in_ready = in_ready_q;
  assign rf_waddr = head_addr_q;
  assign rf_wdata = head_data_q;
  assign sel_err  = sel_err_q;

  always_comb begin
    state_d     = state_q;
    head_addr_d = head_addr_q;
    head_data_d = head_data_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    sel_err_d   = sel_err_q | (accept & ~sel_ok);
    unique case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          state_d     = BUF_ONE;
          head_addr_d = in_rd;
          head_data_d = sel_data;
        end
      end
      BUF_ONE: begin
        if (push && !pop) begin
          state_d     = BUF_TWO;
          skid_addr_d = in_rd;
          skid_data_d = sel_data;
        end else if (push && pop) begin
          head_addr_d = in_rd;
          head_data_d = sel_data;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (pop) begin
          state_d     = BUF_ONE;
          head_addr_d = skid_addr_q;
          head_data_d = skid_data_q;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BUF_EMPTY;
      in_ready_q  <= 1'b1;
      sel_err_q   <= 1'b0;
      head_addr_q <= '0;
      head_data_q <= '0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != BUF_TWO);
      sel_err_q   <= sel_err_d;
      head_addr_q <= head_addr_d;
      head_data_q <= head_data_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_cpu_writeback_stage.sv
// Self-checking bench for cpu_writeback_stage against a queue-based reference.
module tb_cpu_writeback_stage;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_sel;
  logic [127:0] in_data;
  logic [4:0]   in_rd;
  logic [1:0]   in_ld_size;
  logic         in_ld_signed;
  logic [1:0]   in_byte_off;
  logic         rf_we;
  logic         rf_ready;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic         sel_err;

  logic         in3_valid;
  logic         in3_ready;
  logic [1:0]   in3_sel;
  logic [95:0]  in3_data;
  logic [4:0]   in3_rd;
  logic         rf3_we;
  logic         rf3_ready;
  logic [4:0]   rf3_waddr;
  logic [31:0]  rf3_wdata;
  logic         sel_err3;

  int errors = 0;
  int checks = 0;

  logic [4:0]  mq_addr[$];
  logic [31:0] mq_data[$];

  cpu_writeback_stage u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .in_rd(in_rd), .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
    .in_byte_off(in_byte_off), .rf_we(rf_we), .rf_ready(rf_ready),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .sel_err(sel_err)
  );

  cpu_writeback_stage #(.NSRC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in3_valid), .in_ready(in3_ready), .in_sel(in3_sel), .in_data(in3_data),
    .in_rd(in3_rd), .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
    .in_byte_off(in_byte_off), .rf_we(rf3_we), .rf_ready(rf3_ready),
    .rf_waddr(rf3_waddr), .rf_wdata(rf3_wdata), .sel_err(sel_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rand_bus();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Value written to the register file, derived from the load rules directly.
  function automatic logic [31:0] ref_result(input logic [1:0] sel, input logic [127:0] bus,
                                             input logic [1:0] sz, input logic sg,
                                             input logic [1:0] off);
    logic [31:0] w;
    int unsigned v;
    w = bus[sel*32 +: 32];
    if (sel != 2'd1) return w;
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) % 256;
      if (sg && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (sz == 2'd1) begin
      v = (w >> (16 * (off / 2))) % 65536;
      if (sg && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return w;
  endfunction

  // Applies one cycle of stimulus and advances the reference FIFO.
  task automatic drive(input logic v, input logic [1:0] sel, input logic [127:0] bus,
                       input logic [4:0] rd, input logic [1:0] sz, input logic sg,
                       input logic [1:0] off, input logic rdy);
    bit acc;
    logic [4:0]  da;
    logic [31:0] dd;
    in_valid = v; in_sel = sel; in_data = bus; in_rd = rd;
    in_ld_size = sz; in_ld_signed = sg; in_byte_off = off; rf_ready = rdy;
    acc = v && (mq_addr.size() < 2);
    if (rdy && mq_addr.size() > 0) begin
      da = mq_addr.pop_front();
      dd = mq_data.pop_front();
    end
    if (acc && rd != 5'd0) begin
      mq_addr.push_back(rd);
      mq_data.push_back(ref_result(sel, bus, sz, sg, off));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 2'd0, 128'd0, 5'd0, 2'd2, 1'b0, 2'd0, rdy);
  endtask

  task automatic test_reset();
    checks++;
    if (rf_we !== 1'b0 || in_ready !== 1'b1 || sel_err !== 1'b0 ||
        rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: we=%b rdy=%b err=%b addr=%0d data=%h, want 0 1 0 0 0",
               rf_we, in_ready, sel_err, rf_waddr, rf_wdata);
    end
    checks++;
    if (rf3_we !== 1'b0 || in3_ready !== 1'b1 || sel_err3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state3: we=%b rdy=%b err=%b, want 0 1 0", rf3_we, in3_ready, sel_err3);
    end
  endtask

  task automatic test_streaming();
    logic [127:0] bus;
    for (int i = 1; i <= 8; i++) begin
      bus = rand_bus();
      drive(1'b1, 2'd0, bus, 5'(i), 2'd2, 1'b0, 2'd0, 1'b1);
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(i) || rf_wdata !== bus[31:0] || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_head[%0d]: we=%b addr=%0d data=%h rdy=%b, want 1 %0d %h 1",
                 i, rf_we, rf_waddr, rf_wdata, in_ready, i, bus[31:0]);
      end
    end
    idle(1'b1);
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: we=%b, want 0", rf_we);
    end
  endtask

  task automatic test_load_extend();
    logic [1:0]   off_t[6];
    logic [1:0]   sz_t[6];
    logic         sg_t[6];
    logic [31:0]  exp_t[6];
    logic [127:0] bus;
    off_t = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd3};
    sz_t  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2};
    sg_t  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_t = '{32'h0000_007F, 32'hFFFF_FF80, 32'hFFFF_80FF, 32'h0000_80FF,
              32'h0000_0080, 32'h80FF_7F01};
    for (int i = 0; i < 6; i++) begin
      bus = rand_bus();
      bus[63:32] = 32'h80FF_7F01;
      drive(1'b1, 2'd1, bus, 5'(20 + i), sz_t[i], sg_t[i], off_t[i], 1'b1);
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(20 + i) || rf_wdata !== exp_t[i]) begin
        errors++;
        $display("FAIL load_ext[%0d]: we=%b addr=%0d data=%h, want 1 %0d %h",
                 i, rf_we, rf_waddr, rf_wdata, 20 + i, exp_t[i]);
      end
    end
    idle(1'b1);
  endtask

  task automatic test_backpressure();
    logic [127:0] items[6];
    logic [1:0]   sels[6];
    logic [4:0]   got[$];
    int           idx;
    bit           saw_stall;
    bit           rdy;
    idx = 0;
    saw_stall = 0;
    for (int i = 0; i < 6; i++) begin
      items[i] = rand_bus();
      sels[i]  = 2'($urandom_range(0, 3));
    end
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (in_ready !== (mq_addr.size() < 2) || rf_we !== (mq_addr.size() > 0)) begin
        errors++;
        $display("FAIL bp_flags[%0d]: rdy=%b we=%b, want rdy=%b we=%b", c, in_ready, rf_we,
                 mq_addr.size() < 2, mq_addr.size() > 0);
      end
      if (mq_addr.size() > 0) begin
        checks++;
        if (rf_waddr !== mq_addr[0] || rf_wdata !== mq_data[0]) begin
          errors++;
          $display("FAIL bp_head[%0d]: addr=%0d data=%h, want %0d %h", c, rf_waddr, rf_wdata,
                   mq_addr[0], mq_data[0]);
        end
      end
      if (!in_ready) saw_stall = 1;
      rdy = !(c >= 2 && c <= 4);
      if (rdy && rf_we) got.push_back(rf_waddr);
      if (idx < 6) begin
        if (mq_addr.size() < 2) begin
          drive(1'b1, sels[idx], items[idx], 5'(11 + idx), 2'd2, 1'b0, 2'd0, rdy);
          idx++;
        end else begin
          drive(1'b1, sels[idx], items[idx], 5'(11 + idx), 2'd2, 1'b0, 2'd0, rdy);
        end
      end else begin
        idle(rdy);
      end
    end
    checks++;
    if (saw_stall !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: in_ready low seen=%b, want 1", saw_stall);
    end
    checks++;
    if (got.size() != 6 || idx != 6) begin
      errors++;
      $display("FAIL bp_count: writes=%0d accepted=%0d, want 6 6", got.size(), idx);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got[i] !== 5'(11 + i)) begin
          errors++;
          $display("FAIL bp_order[%0d]: addr=%0d, want %0d", i, got[i], 11 + i);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [127:0] bus;
    bus = rand_bus();
    drive(1'b1, 2'd0, bus, 5'd3, 2'd2, 1'b0, 2'd0, 1'b1);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin
      errors++;
      $display("FAIL zero_rd3: we=%b addr=%0d, want 1 3", rf_we, rf_waddr);
    end
    drive(1'b1, 2'd0, bus, 5'd0, 2'd2, 1'b0, 2'd0, 1'b1);
    checks++;
    if (rf_we !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_rd0: we=%b rdy=%b, want 0 1", rf_we, in_ready);
    end
    drive(1'b1, 2'd2, bus, 5'd4, 2'd2, 1'b0, 2'd0, 1'b1);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== bus[95:64]) begin
      errors++;
      $display("FAIL zero_rd4: we=%b addr=%0d data=%h, want 1 4 %h", rf_we, rf_waddr, rf_wdata,
               bus[95:64]);
    end
    idle(1'b1);
    // Stalled variant: rd=0 must not occupy a slot.
    drive(1'b1, 2'd0, bus, 5'd3, 2'd2, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 2'd0, bus, 5'd0, 2'd2, 1'b0, 2'd0, 1'b0);
    checks++;
    if (in_ready !== 1'b1 || rf_waddr !== 5'd3) begin
      errors++;
      $display("FAIL zero_slot: rdy=%b addr=%0d, want 1 3", in_ready, rf_waddr);
    end
    drive(1'b1, 2'd0, bus, 5'd4, 2'd2, 1'b0, 2'd0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || rf_waddr !== 5'd3) begin
      errors++;
      $display("FAIL zero_full: rdy=%b addr=%0d, want 0 3", in_ready, rf_waddr);
    end
    idle(1'b1);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4) begin
      errors++;
      $display("FAIL zero_next: we=%b addr=%0d, want 1 4", rf_we, rf_waddr);
    end
    idle(1'b1);
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL zero_drain: we=%b, want 0", rf_we);
    end
  endtask

  task automatic test_bad_select();
    logic [95:0] bus;
    bus = {$urandom, $urandom, $urandom};
    in_ld_size = 2'd2; rf3_ready = 1'b1;
    in3_valid = 1'b1; in3_sel = 2'd2; in3_rd = 5'd7; in3_data = bus;
    @(posedge clk); @(negedge clk);
    checks++;
    if (rf3_we !== 1'b1 || rf3_waddr !== 5'd7 || rf3_wdata !== bus[95:64] || sel_err3 !== 1'b0) begin
      errors++;
      $display("FAIL badsel_good: we=%b addr=%0d data=%h err=%b, want 1 7 %h 0",
               rf3_we, rf3_waddr, rf3_wdata, sel_err3, bus[95:64]);
    end
    in3_sel = 2'd3; in3_rd = 5'd5;
    @(posedge clk); @(negedge clk);
    checks++;
    if (rf3_we !== 1'b1 || rf3_waddr !== 5'd5 || rf3_wdata !== 32'd0 || sel_err3 !== 1'b1) begin
      errors++;
      $display("FAIL badsel_bad: we=%b addr=%0d data=%h err=%b, want 1 5 0 1",
               rf3_we, rf3_waddr, rf3_wdata, sel_err3);
    end
    in3_valid = 1'b0; in3_sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (sel_err3 !== 1'b1 || rf3_we !== 1'b0) begin
        errors++;
        $display("FAIL badsel_sticky[%0d]: err=%b we=%b, want 1 0", i, sel_err3, rf3_we);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] bus;
    for (int c = 0; c < 300; c++) begin
      checks++;
      if (in_ready !== (mq_addr.size() < 2) || rf_we !== (mq_addr.size() > 0) ||
          (mq_addr.size() > 0 && (rf_waddr !== mq_addr[0] || rf_wdata !== mq_data[0]))) begin
        errors++;
        $display("FAIL rand[%0d]: rdy=%b we=%b addr=%0d data=%h, want rdy=%b we=%b addr=%0d data=%h",
                 c, in_ready, rf_we, rf_waddr, rf_wdata, mq_addr.size() < 2, mq_addr.size() > 0,
                 (mq_addr.size() > 0) ? mq_addr[0] : 5'd0, (mq_addr.size() > 0) ? mq_data[0] : 32'd0);
      end
      bus = rand_bus();
      drive(($urandom % 4) != 0, 2'($urandom), bus,
            (($urandom % 8) == 0) ? 5'd0 : 5'($urandom), 2'($urandom), 1'($urandom),
            2'($urandom), ($urandom % 4) != 0);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);
    checks++;
    if (rf_we !== 1'b0 || mq_addr.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: we=%b model=%0d, want 0 0", rf_we, mq_addr.size());
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 2'd0, rand_bus(), 5'd9, 2'd2, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 2'd0, rand_bus(), 5'd10, 2'd2, 1'b0, 2'd0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || rf_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_prefill: rdy=%b we=%b, want 0 1", in_ready, rf_we);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rf_we !== 1'b0 || in_ready !== 1'b1 || sel_err3 !== 1'b0 ||
        rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      errors++;
      $display("FAIL rst_async: we=%b rdy=%b err3=%b addr=%0d data=%h, want 0 1 0 0 0",
               rf_we, in_ready, sel_err3, rf_waddr, rf_wdata);
    end
    mq_addr.delete();
    mq_data.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      checks++;
      if (rf_we !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_after[%0d]: we=%b rdy=%b, want 0 1", i, rf_we, in_ready);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = '0; in_data = '0; in_rd = '0;
    in_ld_size = 2'd2; in_ld_signed = 1'b0; in_byte_off = '0; rf_ready = 1'b0;
    in3_valid = 1'b0; in3_sel = '0; in3_data = '0; in3_rd = '0; rf3_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_streaming();
    test_load_extend();
    test_backpressure();
    test_zero_reg();
    test_bad_select();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
